// File: rtl/paint_pkg.sv
// Shared definitions for the paint framebuffer writer: drain FSM states and
// framebuffer geometry constants.
package paint_pkg;

  localparam int FB_LOG2_DEF = 6;
  localparam int ADDR_W_DEF  = 2 * FB_LOG2_DEF;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } drain_state_t;

  function automatic int addr_width(input int fb_log2);
    return 2 * fb_log2;
  endfunction

endpackage

// File: rtl/paint_req_fifo.sv
// Synchronous request FIFO with a registered occupancy count; pointers wrap
// naturally because DEPTH is a power of two.
module paint_req_fifo
  import paint_pkg::*;
#(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = ADDR_W_DEF + 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  // A simultaneous pop frees the slot the push is about to use.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/paint_fb_writer.sv
// Buffers paint requests, clips off-screen pixels and drains them into the
// framebuffer. Optional clip counter enabled by PAINT_FB_WRITER_CLIP_CNT_EN.
module paint_fb_writer
  import paint_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int FB_LOG2    = FB_LOG2_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 paint,
  input  logic [7:0]           px_data,
  input  logic [8:0]           in_x,
  input  logic [8:0]           in_y,
  input  logic                 flush,
  input  logic                 mem_gnt,
  output logic                 mem_we,
  output logic [2*FB_LOG2-1:0] mem_addr,
  output logic [7:0]           mem_wdata,
  output logic                 ready,
  output logic                 writer_done
`ifdef PAINT_FB_WRITER_CLIP_CNT_EN
  ,
  output logic [7:0]           clip_cnt
`endif
);

  localparam int AW      = addr_width(FB_LOG2);
  localparam int ENTRY_W = AW + 8;
  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;

  drain_state_t       state;
  drain_state_t       state_next;
  logic               clip;
  logic               accept;
  logic               push;
  logic               pop;
  logic [ENTRY_W-1:0] entry;
  logic [ENTRY_W-1:0] head;
  logic               full;
  logic               empty;
  logic [CNT_W-1:0]   count;
  logic               flush_pend;

  assign clip   = ((in_x >> FB_LOG2) != 9'd0) || ((in_y >> FB_LOG2) != 9'd0);
  assign ready  = !full;
  assign accept = paint && ready;
  assign push   = accept && !clip;
  assign entry  = {in_y[FB_LOG2-1:0], in_x[FB_LOG2-1:0], px_data};

  paint_req_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (entry),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Entering ISSUE on the accepting edge gives the one-cycle write latency.
  always_comb begin
    state_next = state;
    mem_we     = 1'b0;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!empty || push) state_next = ISSUE;
      end
      ISSUE: begin
        mem_we = 1'b1;
        if (mem_gnt) begin
          pop = 1'b1;
          if (count == CNT_W'(1) && !push) state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign mem_addr  = mem_we ? head[ENTRY_W-1:8] : '0;
  assign mem_wdata = mem_we ? head[7:0] : 8'h00;

  assign writer_done = flush_pend && empty && (state == IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              flush_pend <= 1'b0;
    else if (writer_done) flush_pend <= 1'b0;
    else if (flush)       flush_pend <= 1'b1;
  end

`ifdef PAINT_FB_WRITER_CLIP_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                     clip_cnt <= 8'd0;
    else if (accept && clip && clip_cnt != 8'hFF) clip_cnt <= clip_cnt + 8'd1;
  end
`endif

endmodule
